// File: rtl/fmap_stream_reader.sv
// Raster read-out of a column-major BRAM feature map into a row-major
// 8-bit valid/ready pixel stream with credit-limited BRAM reads.
//
// Ports:
//   clk, rst         clock, synchronous active-high reset
//   frame_ready      1-cycle pulse, a full fmap is in BRAM
//   bram_addr_b      port-B word address (BASE_ADDR + column)
//   bram_en_b        port-B read enable, one read per high cycle
//   bram_rddata_b    port-B data, valid RD_LAT cycles after enable
//   m_tdata          pixel value
//   m_tvalid         pixel valid
//   m_tready         downstream ready
//   m_tuser          first pixel of a frame
//   m_tlast          last pixel of a row
//   busy             frame accepted and not yet done
//   frame_done       1-cycle pulse after the final beat
//   overrun          sticky: frame_ready seen while busy
module fmap_stream_reader #(
  parameter int          PIX_H     = 24,
  parameter int          PIX_W     = 24,
  parameter logic [11:0] BASE_ADDR = 12'h000,
  parameter int          RD_LAT    = 1
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         frame_ready,
  output logic [11:0]  bram_addr_b,
  output logic         bram_en_b,
  input  logic [191:0] bram_rddata_b,
  output logic [7:0]   m_tdata,
  output logic         m_tvalid,
  input  logic         m_tready,
  output logic         m_tuser,
  output logic         m_tlast,
  output logic         busy,
  output logic         frame_done,
  output logic         overrun
);

  localparam int RW = (PIX_H > 1) ? $clog2(PIX_H) : 1;
  localparam int CW = (PIX_W > 1) ? $clog2(PIX_W) : 1;
  localparam int D  = RD_LAT + 1;
  localparam int OW = $clog2(2 * D + 1);

  if (int'(BASE_ADDR) + PIX_W - 1 > 4095) begin : g_addr_chk
    $error("BASE_ADDR+PIX_W-1 exceeds 12-bit address space");
  end
  if (RD_LAT < 1 || RD_LAT > 2) begin : g_lat_chk
    $error("RD_LAT must be 1 or 2");
  end
  if (PIX_H * 8 > 192) begin : g_h_chk
    $error("PIX_H*8 exceeds BRAM word width");
  end

  typedef enum logic [1:0] {
    S_IDLE, S_ISSUE, S_DRAIN, S_DONE
  } state_t;

  state_t        state_q, state_d;
  logic [RW-1:0] row_q, row_d;
  logic [CW-1:0] col_q, col_d;
  logic          ovr_q;

  // read tag pipeline, stage RD_LAT-1 lines up with returning data
  logic [RD_LAT-1:0] vld_q;
  logic [RW-1:0]     tr_q [RD_LAT];
  logic [CW-1:0]     tc_q [RD_LAT];

  // shift FIFO: entry 0 drives the stream outputs directly
  logic [7:0]    dat_q [D];
  logic [7:0]    dat_d [D];
  logic [D-1:0]  usr_q, usr_d;
  logic [D-1:0]  lst_q, lst_d;
  logic [OW-1:0] cnt_q, cnt_d;

  logic [OW-1:0] inflight;
  logic [OW-1:0] outst;
  logic [OW-1:0] wpos;
  logic          deq, enq, issue, last_rc;
  logic [7:0]    rbyte;
  logic          rusr, rlst;

  always_comb begin
    inflight = '0;
    for (int i = 0; i < RD_LAT; i++) begin
      inflight = inflight + OW'(vld_q[i]);
    end
    deq   = (cnt_q != '0) && m_tready;
    enq   = vld_q[RD_LAT-1];
    // a same-cycle dequeue frees a slot, keeping 1 pixel/cycle
    outst = cnt_q + inflight - OW'(deq);
    issue = (state_q == S_ISSUE) && (outst < OW'(D));
    last_rc = (row_q == RW'(PIX_H - 1)) &&
              (col_q == CW'(PIX_W - 1));
    rbyte = bram_rddata_b[{tr_q[RD_LAT-1], 3'b000} +: 8];
    rusr  = (tr_q[RD_LAT-1] == '0) && (tc_q[RD_LAT-1] == '0);
    rlst  = tc_q[RD_LAT-1] == CW'(PIX_W - 1);
  end

  always_comb begin
    state_d = state_q;
    row_d   = row_q;
    col_d   = col_q;
    unique case (state_q)
      S_IDLE: begin
        row_d = '0;
        col_d = '0;
        if (frame_ready) state_d = S_ISSUE;
      end
      S_ISSUE: begin
        if (issue) begin
          if (last_rc) begin
            row_d   = '0;
            col_d   = '0;
            state_d = S_DRAIN;
          end else if (col_q == CW'(PIX_W - 1)) begin
            col_d = '0;
            row_d = row_q + 1'b1;
          end else begin
            col_d = col_q + 1'b1;
          end
        end
      end
      S_DRAIN: begin
        if (inflight == '0 && cnt_q == OW'(deq))
          state_d = S_DONE;
      end
      S_DONE:  state_d = S_IDLE;
      default: state_d = S_IDLE;
    endcase
  end

  always_comb begin
    dat_d = dat_q;
    usr_d = usr_q;
    lst_d = lst_q;
    if (deq) begin
      for (int i = 0; i < D - 1; i++) begin
        dat_d[i] = dat_q[i+1];
        usr_d[i] = usr_q[i+1];
        lst_d[i] = lst_q[i+1];
      end
    end
    wpos = cnt_q - OW'(deq);
    for (int i = 0; i < D; i++) begin
      if (enq && wpos == OW'(i)) begin
        dat_d[i] = rbyte;
        usr_d[i] = rusr;
        lst_d[i] = rlst;
      end
    end
    cnt_d = cnt_q + OW'(enq) - OW'(deq);
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= S_IDLE;
      row_q   <= '0;
      col_q   <= '0;
      ovr_q   <= 1'b0;
      vld_q   <= '0;
      cnt_q   <= '0;
      usr_q   <= '0;
      lst_q   <= '0;
      for (int i = 0; i < RD_LAT; i++) begin
        tr_q[i] <= '0;
        tc_q[i] <= '0;
      end
      for (int i = 0; i < D; i++) dat_q[i] <= '0;
    end else begin
      state_q <= state_d;
      row_q   <= row_d;
      col_q   <= col_d;
      ovr_q   <= ovr_q | (frame_ready && state_q != S_IDLE);
      vld_q[0] <= issue;
      tr_q[0]  <= row_q;
      tc_q[0]  <= col_q;
      for (int i = 1; i < RD_LAT; i++) begin
        vld_q[i] <= vld_q[i-1];
        tr_q[i]  <= tr_q[i-1];
        tc_q[i]  <= tc_q[i-1];
      end
      cnt_q <= cnt_d;
      usr_q <= usr_d;
      lst_q <= lst_d;
      dat_q <= dat_d;
    end
  end

  assign bram_en_b   = issue;
  assign bram_addr_b = BASE_ADDR + 12'(col_q);
  assign m_tvalid    = cnt_q != '0;
  assign m_tdata     = dat_q[0];
  assign m_tuser     = usr_q[0];
  assign m_tlast     = lst_q[0];
  assign busy        = (state_q == S_ISSUE) || (state_q == S_DRAIN);
  assign frame_done  = state_q == S_DONE;
  assign overrun     = ovr_q;

endmodule

// File: tb/tb_fmap_stream_reader.sv
// Directed bench for fmap_stream_reader: two instances,
// RD_LAT=1 (main) and RD_LAT=2 (latency/throughput).
module tb_fmap_stream_reader;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic rst = 1'b1;
  logic fr1 = 1'b0, fr2 = 1'b0;
  logic rmode = 1'b0, rbit = 1'b0, rdy_fix = 1'b1;
  logic rdy1;
  assign rdy1 = rmode ? rbit : rdy_fix;

  logic [11:0]  addr1, addr2;
  logic         en1, en2;
  logic [191:0] rd1 = '0, rd2 = '0, p2 = '0;
  logic [7:0]   d1, d2;
  logic v1, u1, l1, busy1, fd1, ovr1;
  logic v2, u2, l2, busy2, fd2, ovr2;

  fmap_stream_reader #(.RD_LAT(1)) dut1 (
    .clk(clk), .rst(rst), .frame_ready(fr1),
    .bram_addr_b(addr1), .bram_en_b(en1),
    .bram_rddata_b(rd1),
    .m_tdata(d1), .m_tvalid(v1), .m_tready(rdy1),
    .m_tuser(u1), .m_tlast(l1), .busy(busy1),
    .frame_done(fd1), .overrun(ovr1)
  );

  fmap_stream_reader #(.RD_LAT(2)) dut2 (
    .clk(clk), .rst(rst), .frame_ready(fr2),
    .bram_addr_b(addr2), .bram_en_b(en2),
    .bram_rddata_b(rd2),
    .m_tdata(d2), .m_tvalid(v2), .m_tready(1'b1),
    .m_tuser(u2), .m_tlast(l2), .busy(busy2),
    .frame_done(fd2), .overrun(ovr2)
  );

  function automatic logic [191:0] mword(int c);
    logic [191:0] w;
    w = '0;
    for (int r = 0; r < 24; r++) w[r*8 +: 8] = 8'((r * 7 + c) % 256);
    return w;
  endfunction

  always @(posedge clk) begin
    if (en1) rd1 <= mword(int'(addr1));
    if (en2) p2 <= mword(int'(addr2));
    rd2 <= p2;
  end

  always @(posedge clk) begin
    #1 rbit = 1'($urandom_range(0, 1));
  end

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  int n_chk = 0, n_pass = 0;

  task automatic chk(input string tag, input int got, input int exp);
    n_chk++;
    if (got == exp) n_pass++;
    else $display("FAIL %s: got %0d expected %0d", tag, got, exp);
  endtask

  // monitor, instance 1
  int nb1 = 0, fbase1 = 0, errs1 = 0, first1 = 0, last1 = 0;
  int nlast1 = 0, iss1 = 0, ndone1 = 0, done1 = 0;
  int stall1 = 0, cred1 = 0, busyd1 = 0, k1;
  logic pv1 = 0, pu1 = 0, pl1 = 0;
  logic [7:0] pd1 = '0;
  logic [7:0] capt1 [576];

  always @(negedge clk) begin
    if (rst) begin
      pv1 = 1'b0;
      iss1 = nb1;
    end else begin
      if (pv1 && !(v1 && d1 == pd1 && u1 == pu1 && l1 == pl1))
        stall1++;
      if (en1 && (iss1 - nb1 - int'(v1 && rdy1)) >= 2) cred1++;
      if (en1) iss1++;
      if (v1 && rdy1) begin
        k1 = nb1 - fbase1;
        if (k1 >= 576) errs1++;
        else begin
          capt1[k1] = d1;
          if (d1 != 8'((k1 / 24) * 7 + k1 % 24)) errs1++;
          if (u1 != (k1 == 0)) errs1++;
          if (l1 != (k1 % 24 == 23)) errs1++;
        end
        if (k1 == 0) first1 = cyc;
        last1 = cyc;
        if (l1) nlast1++;
        nb1++;
      end
      if (fd1) begin
        ndone1++;
        done1 = cyc;
        busyd1 = int'(busy1);
      end
      pv1 = v1 && !rdy1;
      pd1 = d1;
      pu1 = u1;
      pl1 = l1;
    end
  end

  // monitor, instance 2
  int nb2 = 0, fbase2 = 0, errs2 = 0, first2 = 0, last2 = 0;
  int ndone2 = 0, done2 = 0, k2;

  always @(negedge clk) begin
    if (!rst) begin
      if (v2) begin
        k2 = nb2 - fbase2;
        if (k2 >= 576) errs2++;
        else begin
          if (d2 != 8'((k2 / 24) * 7 + k2 % 24)) errs2++;
          if (u2 != (k2 == 0)) errs2++;
          if (l2 != (k2 % 24 == 23)) errs2++;
        end
        if (k2 == 0) first2 = cyc;
        last2 = cyc;
        nb2++;
      end
      if (fd2) begin
        ndone2++;
        done2 = cyc;
      end
    end
  end

  task automatic step(input int n);
    repeat (n) begin
      @(posedge clk);
      #1;
    end
  endtask

  task automatic pulse1(output int f);
    f = cyc;
    fr1 = 1'b1;
    step(1);
    fr1 = 1'b0;
  endtask

  task automatic wait_done1(input int tgt, input string tag);
    int t;
    t = 0;
    while (ndone1 < tgt && t < 6000) begin
      step(1);
      t++;
    end
    chk(tag, ndone1, tgt);
  endtask

  task automatic wait_beats1(input int n, input string tag);
    int t;
    t = 0;
    while (nb1 - fbase1 < n && t < 3000) begin
      step(1);
      t++;
    end
    chk(tag, nb1 - fbase1, n);
  endtask

  int f, e0, nl0, s0, dn0, t;

  initial begin
    step(3);
    rst = 1'b0;
    step(1);
    // reset state
    chk("rst_valid", int'(v1), 0);
    chk("rst_busy", int'(busy1), 0);
    chk("rst_addr", int'(addr1), 0);
    chk("rst_misc", int'({en1, fd1, ovr1}), 0);

    // 1: full frame at full rate
    fbase1 = nb1; e0 = errs1; nl0 = nlast1;
    pulse1(f);
    chk("t1_busy", int'(busy1), 1);
    wait_done1(1, "t1_done");
    chk("t1_first_lat", first1 - f, 3);
    chk("t1_beat0", int'(capt1[0]), 0);
    chk("t1_beat2", int'(capt1[2]), 2);
    chk("t1_r1c1", int'(capt1[25]), 8);
    chk("t1_beats", nb1 - fbase1, 576);
    chk("t1_contig", last1 - first1, 575);
    chk("t1_tlast", nlast1 - nl0, 24);
    chk("t1_errs", errs1 - e0, 0);
    chk("t1_done_lat", done1 - last1, 1);
    chk("t1_busy_done", busyd1, 0);
    step(5);
    chk("t1_one_done", ndone1, 1);

    // 2: random backpressure
    fbase1 = nb1; e0 = errs1;
    rmode = 1'b1;
    pulse1(f);
    wait_done1(2, "t2_done");
    rmode = 1'b0;
    chk("t2_beats", nb1 - fbase1, 576);
    chk("t2_errs", errs1 - e0, 0);
    chk("t2_stall", stall1, 0);
    chk("t2_credit", cred1, 0);

    // 3: long stall right at frame start
    step(3);
    fbase1 = nb1; e0 = errs1; s0 = iss1;
    rdy_fix = 1'b0;
    pulse1(f);
    step(100);
    chk("t3_reads", iss1 - s0, 2);
    chk("t3_valid", int'(v1), 1);
    chk("t3_data", int'(d1), 0);
    rdy_fix = 1'b1;
    wait_done1(3, "t3_done");
    chk("t3_beats", nb1 - fbase1, 576);
    chk("t3_errs", errs1 - e0, 0);
    chk("t3_stall", stall1, 0);

    // 4: second frame_ready mid-frame
    step(3);
    fbase1 = nb1; e0 = errs1;
    pulse1(f);
    wait_beats1(100, "t4_reach100");
    pulse1(f);
    chk("t4_overrun", int'(ovr1), 1);
    wait_done1(4, "t4_done");
    chk("t4_beats", nb1 - fbase1, 576);
    chk("t4_errs", errs1 - e0, 0);
    step(10);
    chk("t4_one_done", ndone1, 4);
    chk("t4_ovr_sticky", int'(ovr1), 1);
    fbase1 = nb1; e0 = errs1;
    pulse1(f);
    wait_done1(5, "t4_restart_done");
    chk("t4_restart_beats", nb1 - fbase1, 576);
    chk("t4_restart_errs", errs1 - e0, 0);
    chk("t4_restart_beat0", int'(capt1[0]), 0);

    // 5: reset mid-frame
    step(3);
    fbase1 = nb1;
    pulse1(f);
    wait_beats1(300, "t5_reach300");
    dn0 = ndone1;
    rst = 1'b1;
    step(1);
    chk("t5_rst_outs",
        int'({v1, busy1, en1, fd1, u1, l1, ovr1, d1}), 0);
    chk("t5_rst_addr", int'(addr1), 0);
    rst = 1'b0;
    step(20);
    chk("t5_no_done", ndone1, dn0);
    fbase1 = nb1; e0 = errs1;
    pulse1(f);
    wait_done1(dn0 + 1, "t5_new_done");
    chk("t5_new_beats", nb1 - fbase1, 576);
    chk("t5_new_errs", errs1 - e0, 0);
    chk("t5_new_beat0", int'(capt1[0]), 0);

    // 6: RD_LAT=2 instance
    step(3);
    fbase2 = nb2; e0 = errs2;
    f = cyc;
    fr2 = 1'b1;
    step(1);
    fr2 = 1'b0;
    t = 0;
    while (ndone2 < 1 && t < 3000) begin
      step(1);
      t++;
    end
    chk("t6_done", ndone2, 1);
    chk("t6_first_lat", first2 - f, 4);
    chk("t6_beats", nb2 - fbase2, 576);
    chk("t6_contig", last2 - first2, 575);
    chk("t6_errs", errs2 - e0, 0);
    chk("t6_done_lat", done2 - last2, 1);

    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end

endmodule
